// File: rtl/bin2bcd_seq_ctrl_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding and digit-adjust constants.
package bin2bcd_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADJUST = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// Request/result bundle between the arithmetic result registers (master)
// and the binary-to-BCD converter (slave).
interface bin2bcd_seq_ctrl_if #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/bin2bcd_seq_ctrl_add3_if_ge5.sv
// Double-dabble digit cell: adds 3 to a BCD digit of 5 or more so that the
// following left shift carries correctly into the next digit.
module add3_if_ge5
    import bin2bcd_seq_ctrl_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din + ADJ_ADD;
        end
    end
endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: one ADJUST + SHIFT pair per input bit,
// reusing a single row of digit-adjust cells on the scratch register.
module bin2bcd_seq_ctrl
    import bin2bcd_seq_ctrl_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    bin2bcd_seq_ctrl_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned SR_W  = BCD_W + BIN_W + 1;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_bin_q, shift_bin_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   adj;
    logic [SR_W-1:0]    shifted;
    logic               carry_out;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        add3_if_ge5 u_cell (
            .din  (scratch_q[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Top bit is the MSB of the top digit falling off the end: the value no
    // longer fits in DIGITS digits, so it is folded into the overflow flag.
    assign shifted   = {scratch_q, shift_bin_q, 1'b0};
    assign carry_out = shifted[SR_W-1];

    always_comb begin
        state_d     = state_q;
        shift_bin_d = shift_bin_q;
        scratch_d   = scratch_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_bin_d = bus.bin_in;
                    scratch_d   = '0;
                    ovf_acc_d   = 1'b0;
                    cnt_d       = CNT_W'(BIN_W);
                    state_d     = ST_ADJUST;
                end
            end
            ST_ADJUST: begin
                scratch_d = adj;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                scratch_d   = shifted[SR_W-2:BIN_W];
                shift_bin_d = shifted[BIN_W-1:0];
                ovf_acc_d   = ovf_acc_q | carry_out;
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d      = shifted[SR_W-2:BIN_W];
                    overflow_d = ovf_acc_q | carry_out;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_ADJUST;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Moore outputs registered from the next state so they line up with it.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_bin_q <= '0;
            scratch_q   <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_bin_q <= shift_bin_d;
            scratch_q   <= scratch_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = overflow_q;

endmodule
